// File: rtl/mux_2_1_arbiter.sv
// Two-requester arbitrated mux with bounded bursts.
// Each grant allows up to MAX_BURST consecutive beats while the other side
// waits. The beat's data and valid are registered one edge after the beat.
module mux_2_1_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               last_grant_q;
    logic               last_grant_d;

    logic               beat_c;
    logic               burst_end_c;
    logic [WIDTH-1:0]   beat_data_c;

    // Beat detection: the current owner is still requesting.
    always_comb begin
        beat_c      = ((state_q == G0) && req0) || ((state_q == G1) && req1);
        beat_data_c = (state_q == G1) ? din1 : din0;
        burst_end_c = beat_c && (cnt_q == CNT_W'(MAX_BURST - 1));
    end

    // Next-state, burst counter and last-grant bookkeeping.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;

        unique case (state_q)
            IDLE: begin
                // On a tie, last_grant=1 hands the mux to requester 0.
                if (req0 && (!req1 || last_grant_q)) begin
                    state_d      = G0;
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
                end else if (req1) begin
                    state_d      = G1;
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                end
            end

            G0: begin
                if (!req0) begin
                    if (req1) begin
                        state_d      = G1;
                        last_grant_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                    cnt_d = '0;
                end else if (burst_end_c) begin
                    // Burst exhausted: hand over if the other side waits,
                    // otherwise keep streaming with a fresh count.
                    if (req1) begin
                        state_d      = G1;
                        last_grant_d = 1'b1;
                    end
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            G1: begin
                if (!req1) begin
                    if (req0) begin
                        state_d      = G0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                    cnt_d = '0;
                end else if (burst_end_c) begin
                    if (req0) begin
                        state_d      = G0;
                        last_grant_d = 1'b0;
                    end
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, grant and output registers; reset wins over any pending beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt0         <= (state_d == G0);
            gnt1         <= (state_d == G1);
            out_valid    <= beat_c;
            if (beat_c) begin
                out_data <= beat_data_c;
            end
        end
    end

    // In G0/G1 last_grant already equals the owner, so it doubles as sel.
    assign sel = last_grant_q;

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Directed bench for mux_2_1_arbiter (WIDTH=8, MAX_BURST=4).
module tb_mux_2_1_arbiter;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_BURST = 4;

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic [WIDTH-1:0] din0;
    logic             req1;
    logic [WIDTH-1:0] din1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    mux_2_1_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .din0      (din0),
        .req1      (req1),
        .din1      (din1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             req0;
        logic             req1;
        logic [WIDTH-1:0] din0;
        logic [WIDTH-1:0] din1;
        logic             gnt0;
        logic             gnt1;
        logic             sel;
        logic             valid;
        logic [WIDTH-1:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic q0, input logic q1,
                                input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                input logic g0, input logic g1, input logic s,
                                input logic v, input logic [WIDTH-1:0] d);
        vec_t t;
        t.rst_n = r;  t.req0 = q0; t.req1 = q1; t.din0 = d0; t.din1 = d1;
        t.gnt0  = g0; t.gnt1 = g1; t.sel  = s;  t.valid = v; t.data = d;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Hold req0, raise req1 after pre_beats beats; count req0 beats req1 waits.
    task automatic fair_run(input int pre_beats, input int exp_wait);
        int  waited;
        bit  granted;
        waited  = 0;
        granted = 0;
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; req0 = 1'b1; din0 = 8'h77; din1 = 8'h99;
        @(posedge clk);
        repeat (pre_beats) @(posedge clk);
        @(negedge clk);
        req1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_data == 8'h77) waited++;
            if (gnt1) begin
                granted = 1;
                break;
            end
        end
        check($sformatf("fair%0d.gnt1_seen", pre_beats), 32'(granted), 32'd1);
        check($sformatf("fair%0d.wait_beats", pre_beats), 32'(waited), 32'(exp_wait));
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;

        // Reset with both requests high.
        add(0,1,1,8'h00,8'h00, 0,0,1,0,8'h00);
        add(0,1,1,8'h00,8'h00, 0,0,1,0,8'h00);
        // Single requester, three beats of A5, then release.
        add(1,1,0,8'hA5,8'h00, 1,0,0,0,8'h00);
        add(1,1,0,8'hA5,8'h00, 1,0,0,1,8'hA5);
        add(1,1,0,8'hA5,8'h00, 1,0,0,1,8'hA5);
        add(1,1,0,8'hA5,8'h00, 1,0,0,1,8'hA5);
        add(1,0,0,8'hA5,8'h00, 0,0,0,0,8'hA5);
        add(1,0,0,8'hA5,8'h00, 0,0,0,0,8'hA5);
        // Tie from IDLE with last_grant=0 goes to requester 1.
        add(1,1,1,8'hA5,8'h66, 0,1,1,0,8'hA5);
        add(1,1,1,8'hA5,8'h66, 0,1,1,1,8'h66);
        // Tie after reset: 4x11, 4x22, 11 with no gaps.
        add(0,0,0,8'h00,8'h00, 0,0,1,0,8'h00);
        add(1,1,1,8'h11,8'h22, 1,0,0,0,8'h00);
        add(1,1,1,8'h11,8'h22, 1,0,0,1,8'h11);
        add(1,1,1,8'h11,8'h22, 1,0,0,1,8'h11);
        add(1,1,1,8'h11,8'h22, 1,0,0,1,8'h11);
        add(1,1,1,8'h11,8'h22, 0,1,1,1,8'h11);
        add(1,1,1,8'h11,8'h22, 0,1,1,1,8'h22);
        add(1,1,1,8'h11,8'h22, 0,1,1,1,8'h22);
        add(1,1,1,8'h11,8'h22, 0,1,1,1,8'h22);
        add(1,1,1,8'h11,8'h22, 1,0,0,1,8'h22);
        add(1,1,1,8'h11,8'h22, 1,0,0,1,8'h11);
        // Owner 0 drops: direct handover, one bubble.
        add(1,0,1,8'h11,8'h22, 0,1,1,0,8'h11);
        add(1,1,1,8'h11,8'h22, 0,1,1,1,8'h22);
        add(1,1,1,8'h11,8'h22, 0,1,1,1,8'h22);
        // Early release of G1 after 2 beats while req0 is high.
        add(1,1,0,8'h11,8'h22, 1,0,0,0,8'h22);
        // Burst wrap: 10 back-to-back beats with no competitor.
        for (int i = 0; i < 10; i++) begin
            add(1,1,0,8'(8'h30 + i),8'h22, 1,0,0,1,8'(8'h30 + i));
        end
        // Reset mid-burst, then requester 1 alone.
        add(1,0,0,8'h00,8'h00, 0,0,0,0,8'h39);
        add(1,1,0,8'h41,8'h00, 1,0,0,0,8'h39);
        add(1,1,0,8'h41,8'h00, 1,0,0,1,8'h41);
        add(0,1,0,8'h42,8'h00, 0,0,1,0,8'h00);
        add(1,0,1,8'h00,8'h55, 0,1,1,0,8'h00);
        add(1,0,1,8'h00,8'h55, 0,1,1,1,8'h55);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            req0  = vecs[i].req0;
            req1  = vecs[i].req1;
            din0  = vecs[i].din0;
            din1  = vecs[i].din1;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.gnt0", i),      32'(gnt0),      32'(vecs[i].gnt0));
            check($sformatf("v%0d.gnt1", i),      32'(gnt1),      32'(vecs[i].gnt1));
            check($sformatf("v%0d.sel", i),       32'(sel),       32'(vecs[i].sel));
            check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d.out_data", i),  32'(out_data),  32'(vecs[i].data));
            check($sformatf("v%0d.gnt_excl", i),  32'(gnt0 & gnt1), 32'd0);
        end

        // Bounded wait for requester 1 from several points in a burst.
        fair_run(0, 4);
        fair_run(2, 2);
        fair_run(3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
